// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN partial-sum datapath.
package snn_pkg;

    localparam int PSUM_W      = 14;
    localparam int VMEM_W      = 18;
    localparam int OUT_DIM     = 21;
    localparam int FILTER_SIZE = 5;
    localparam int PPE_BASE    = 5;
    localparam int IMEM_ID     = 10;

    typedef enum logic [1:0] {
        OP_PSUM  = 2'd0,
        OP_SPIKE = 2'd1,
        OP_CTRL  = 2'd2
    } opcode_e;

    typedef logic signed [PSUM_W-1:0] psum_t;
    typedef logic signed [VMEM_W-1:0] vmem_t;
    typedef logic [8:0]               pix_idx_t;

    // Clamp a one-bit-wider sum back into the membrane range.
    function automatic vmem_t sat_vmem(input logic signed [VMEM_W:0] x);
        if (x[VMEM_W] != x[VMEM_W-1])
            sat_vmem = x[VMEM_W] ? {1'b1, {(VMEM_W-1){1'b0}}} : {1'b0, {(VMEM_W-1){1'b1}}};
        else
            sat_vmem = x[VMEM_W-1:0];
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// Small circular FIFO holding one source PPE's partial sums in arrival order.
module psum_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/spe_psum_accumulator.sv
// Aligns the per-row partial sums of one output pixel, integrates them into the
// stored membrane potential and emits a thresholded spike per owned pixel.
module spe_psum_accumulator #(
    parameter int SPE_ID      = 0,
    parameter int FILTER_SIZE = snn_pkg::FILTER_SIZE,
    parameter int OUT_DIM     = snn_pkg::OUT_DIM,
    parameter int PPE_BASE    = snn_pkg::PPE_BASE,
    parameter int PSUM_W      = snn_pkg::PSUM_W,
    parameter int VMEM_W      = snn_pkg::VMEM_W,
    parameter logic signed [VMEM_W-1:0] THRESH = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_src,
    input  logic [PSUM_W-1:0] in_psum,
    input  logic              ts_done,
    input  logic              img_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_spike,
    output logic [8:0]        out_pix,
    output logic [VMEM_W-1:0] out_vmem,
    output logic              ts_complete,
    output logic              err_drop
);
    import snn_pkg::*;

    localparam int NCOL  = (OUT_DIM - 1 - SPE_ID) / FILTER_SIZE + 1;
    localparam int NPIX  = OUT_DIM * NCOL;
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam int RC_W  = $clog2(OUT_DIM + FILTER_SIZE);
    localparam int SUM_W = PSUM_W + $clog2(FILTER_SIZE);

    logic [FILTER_SIZE-1:0]             src_hit, fifo_push, fifo_full, fifo_empty;
    logic [FILTER_SIZE-1:0][PSUM_W-1:0] fifo_head;
    logic                               src_legal;

    logic [VMEM_W-1:0] vmem_mem [NPIX];

    logic              a_vld_q, a_vld_d, a_last_q, a_last_d;
    logic [SUM_W-1:0]  a_sum_q, a_sum_d;
    logic [VMEM_W-1:0] a_vmem_q, a_vmem_d;
    logic [IDX_W-1:0]  a_idx_q, a_idx_d;
    pix_idx_t          a_pix_q, a_pix_d;

    logic              out_valid_q, out_valid_d, out_spike_q, out_spike_d, out_last_q, out_last_d;
    pix_idx_t          out_pix_q, out_pix_d;
    logic [VMEM_W-1:0] out_vmem_q, out_vmem_d;

    logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
    logic [IDX_W-1:0]  idx_q, idx_d, clr_idx_q, clr_idx_d;
    logic              ts_complete_q, ts_complete_d, err_drop_q, err_drop_d;
    logic              pend_q, pend_d, pend_img_q, pend_img_d, clr_act_q, clr_act_d;

    logic              pend_any, img_any, apply, b_free, a_adv, a_fire, spike;
    logic [VMEM_W:0]   v_full;
    logic [VMEM_W-1:0] v_sat, v_new;

    always_comb begin
        src_hit = '0;
        for (int i = 0; i < FILTER_SIZE; i++) src_hit[i] = (int'(in_src) == PPE_BASE + i);
        src_legal = |src_hit;
        in_ready  = ~|(src_hit & fifo_full);
        fifo_push = src_hit & {FILTER_SIZE{in_valid && in_ready}};
    end

    for (genvar g = 0; g < FILTER_SIZE; g++) begin : g_fifo
        psum_fifo #(.WIDTH(PSUM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (fifo_push[g]),
            .din   (in_psum),
            .pop   (a_fire),
            .dout  (fifo_head[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    // Frame control waits for an empty pipeline so an in-flight pixel finishes
    // against the old counters; stage A stays stalled until the clear lands.
    always_comb begin
        pend_any = pend_q || ts_done || img_start;
        img_any  = pend_img_q || img_start;
        apply    = pend_any && !a_vld_q && !out_valid_q;
        b_free   = !out_valid_q || out_ready;
        a_adv    = a_vld_q && b_free;
        a_fire   = (fifo_empty == '0) && (!a_vld_q || b_free) && !pend_any && !clr_act_q
                   && (idx_q != IDX_W'(NPIX));
    end

    always_comb begin
        a_sum_d = '0;
        for (int i = 0; i < FILTER_SIZE; i++)
            a_sum_d = a_sum_d + {{(SUM_W-PSUM_W){fifo_head[i][PSUM_W-1]}}, fifo_head[i]};
        a_vmem_d = vmem_mem[idx_q];
        a_idx_d  = idx_q;
        a_pix_d  = pix_idx_t'(int'(row_q) * OUT_DIM + int'(col_q));
        a_last_d = (idx_q == IDX_W'(NPIX - 1));
        a_vld_d  = a_fire || (a_vld_q && !a_adv);
    end

    always_comb begin
        v_full = {a_vmem_q[VMEM_W-1], a_vmem_q} + {{(VMEM_W+1-SUM_W){a_sum_q[SUM_W-1]}}, a_sum_q};
        if (v_full[VMEM_W] != v_full[VMEM_W-1])
            v_sat = v_full[VMEM_W] ? {1'b1, {(VMEM_W-1){1'b0}}} : {1'b0, {(VMEM_W-1){1'b1}}};
        else
            v_sat = v_full[VMEM_W-1:0];
        spike = ($signed(v_sat) >= THRESH);
        v_new = spike ? '0 : v_sat;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_spike_d = out_spike_q;
        out_pix_d   = out_pix_q;
        out_vmem_d  = out_vmem_q;
        out_last_d  = out_last_q;
        if (a_adv) begin
            out_valid_d = 1'b1;
            out_spike_d = spike;
            out_pix_d   = a_pix_q;
            out_vmem_d  = v_new;
            out_last_d  = a_last_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        row_d         = row_q;
        col_d         = col_q;
        idx_d         = idx_q;
        ts_complete_d = ts_complete_q;
        clr_act_d     = clr_act_q;
        clr_idx_d     = clr_idx_q;
        if (apply) begin
            row_d         = '0;
            col_d         = RC_W'(SPE_ID);
            idx_d         = '0;
            ts_complete_d = 1'b0;
        end else begin
            if (a_fire) begin
                idx_d = idx_q + 1'b1;
                if (int'(col_q) + FILTER_SIZE > OUT_DIM - 1) begin
                    col_d = RC_W'(SPE_ID);
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + RC_W'(FILTER_SIZE);
                end
            end
            if (out_valid_q && out_ready && out_last_q) ts_complete_d = 1'b1;
        end
        if (apply && img_any) begin
            clr_act_d = 1'b1;
            clr_idx_d = '0;
        end else if (clr_act_q) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == IDX_W'(NPIX - 1)) clr_act_d = 1'b0;
        end
        pend_d     = pend_any && !apply;
        pend_img_d = img_any && !apply;
        err_drop_d = in_valid && !src_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q       <= 1'b0;
            a_last_q      <= 1'b0;
            a_sum_q       <= '0;
            a_vmem_q      <= '0;
            a_idx_q       <= '0;
            a_pix_q       <= '0;
            out_valid_q   <= 1'b0;
            out_spike_q   <= 1'b0;
            out_pix_q     <= '0;
            out_vmem_q    <= '0;
            out_last_q    <= 1'b0;
            row_q         <= '0;
            col_q         <= RC_W'(SPE_ID);
            idx_q         <= '0;
            ts_complete_q <= 1'b0;
            err_drop_q    <= 1'b0;
            pend_q        <= 1'b0;
            pend_img_q    <= 1'b0;
            clr_act_q     <= 1'b0;
            clr_idx_q     <= '0;
        end else begin
            a_vld_q <= a_vld_d;
            if (a_fire) begin
                a_sum_q  <= a_sum_d;
                a_vmem_q <= a_vmem_d;
                a_idx_q  <= a_idx_d;
                a_pix_q  <= a_pix_d;
                a_last_q <= a_last_d;
            end
            out_valid_q   <= out_valid_d;
            out_spike_q   <= out_spike_d;
            out_pix_q     <= out_pix_d;
            out_vmem_q    <= out_vmem_d;
            out_last_q    <= out_last_d;
            row_q         <= row_d;
            col_q         <= col_d;
            idx_q         <= idx_d;
            ts_complete_q <= ts_complete_d;
            err_drop_q    <= err_drop_d;
            pend_q        <= pend_d;
            pend_img_q    <= pend_img_d;
            clr_act_q     <= clr_act_d;
            clr_idx_q     <= clr_idx_d;
        end
    end

    // Membrane storage survives reset; only the img_start sweep zeroes it.
    always_ff @(posedge clk) begin
        if (clr_act_q)  vmem_mem[clr_idx_q] <= '0;
        else if (a_adv) vmem_mem[a_idx_q]   <= v_new;
    end

    assign out_valid   = out_valid_q;
    assign out_spike   = out_spike_q;
    assign out_pix     = out_pix_q;
    assign out_vmem    = out_vmem_q;
    assign ts_complete = ts_complete_q;
    assign err_drop    = err_drop_q;

endmodule

// File: tb/tb_spe_psum_accumulator.sv
// Scoreboard bench: two accumulators (SPE 0 and SPE 2) share stimulus wiring.
module tb_spe_psum_accumulator;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid0, in_valid2, ts_done, img_start, out_ready;
    logic [3:0]  in_src;
    logic [13:0] in_psum;
    logic        in_ready0, out_valid0, out_spike0, ts_complete0, err_drop0;
    logic        in_ready2, out_valid2, out_spike2, ts_complete2, err_drop2;
    logic [8:0]  out_pix0, out_pix2;
    logic [17:0] out_vmem0, out_vmem2;

    spe_psum_accumulator #(.SPE_ID(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_src(in_src), .in_psum(in_psum), .ts_done(ts_done), .img_start(img_start),
        .out_valid(out_valid0), .out_ready(out_ready), .out_spike(out_spike0),
        .out_pix(out_pix0), .out_vmem(out_vmem0), .ts_complete(ts_complete0),
        .err_drop(err_drop0));

    spe_psum_accumulator #(.SPE_ID(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_src(in_src), .in_psum(in_psum), .ts_done(ts_done), .img_start(img_start),
        .out_valid(out_valid2), .out_ready(out_ready), .out_spike(out_spike2),
        .out_pix(out_pix2), .out_vmem(out_vmem2), .ts_complete(ts_complete2),
        .err_drop(err_drop2));

    typedef struct packed {
        logic [8:0]  pix;
        logic        spike;
        logic [17:0] vmem;
    } exp_t;

    exp_t q0[$];
    exp_t q2[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic expect_px(input int sel, input int pix, input int spk, input int vm);
        exp_t e;
        e.pix   = 9'(pix);
        e.spike = 1'(spk);
        e.vmem  = 18'(vm);
        if (sel == 0) q0.push_back(e);
        else          q2.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid0 && out_ready) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL u0_unexpected: got pix %0d expected none", out_pix0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("u0_pix", out_pix0, e.pix);
                chk("u0_spike", out_spike0, e.spike);
                chk("u0_vmem", $signed(out_vmem0), $signed(e.vmem));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready) begin
            if (q2.size() == 0) begin
                checks++; failures++;
                $display("FAIL u2_unexpected: got pix %0d expected none", out_pix2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("u2_pix", out_pix2, e.pix);
                chk("u2_spike", out_spike2, e.spike);
                chk("u2_vmem", $signed(out_vmem2), $signed(e.vmem));
            end
        end
    end

    task automatic push(input int sel, input int src, input int val);
        int n;
        @(negedge clk);
        in_src  = 4'(src);
        in_psum = 14'(val);
        if (sel == 0) in_valid0 = 1'b1;
        else          in_valid2 = 1'b1;
        #1;
        n = 0;
        while (!((sel == 0) ? in_ready0 : in_ready2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL push_timeout: got in_ready 0 expected 1 src %0d", src);
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic push_pix(input int sel, input int val);
        for (int s = 5; s <= 9; s++) push(sel, s, val);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q2.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++; failures++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", q0.size(), q2.size());
        end
        @(negedge clk);
    endtask

    task automatic img_clear();
        @(negedge clk); img_start = 1'b1;
        @(negedge clk); img_start = 1'b0;
        repeat (120) @(negedge clk);
    endtask

    task automatic ts_pulse();
        @(negedge clk); ts_done = 1'b1;
        @(negedge clk); ts_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0]  held_pix;
        logic [17:0] held_vm;
        int vexp [4] = '{-40960, -81920, -122880, -131072};
        rst_n = 1'b0; in_valid0 = 1'b0; in_valid2 = 1'b0; in_src = '0; in_psum = '0;
        ts_done = 1'b0; img_start = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_spike", out_spike0, 0);
        chk("rst_out_pix", out_pix0, 0);
        chk("rst_out_vmem", out_vmem0, 0);
        chk("rst_ts_complete", ts_complete0, 0);
        chk("rst_err_drop", err_drop0, 0);
        chk("rst_in_ready", in_ready0, 1);
        rst_n = 1'b1;

        // Interleaved sources, sum 80 crosses the threshold; 2-cycle latency.
        img_clear();
        expect_px(0, 0, 1, 0);
        push(0, 9, 10); push(0, 5, 20); push(0, 7, 5); push(0, 6, 15); push(0, 8, 30);
        @(negedge clk); @(negedge clk);
        chk("lat_cycle1_valid", out_valid0, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid0, 1);
        drain();

        // Residual potential carries across a timestep, then resets after a spike.
        img_clear();
        expect_px(0, 0, 0, 50);
        push_pix(0, 10); drain();
        ts_pulse();
        expect_px(0, 0, 1, 0);
        push_pix(0, 3); drain();
        ts_pulse();
        expect_px(0, 0, 0, 5);
        push_pix(0, 1); drain();

        // Illegal sources are swallowed with a one-cycle error pulse.
        @(negedge clk); in_src = 4'd3; in_psum = 14'd100; in_valid0 = 1'b1; #1;
        chk("illegal3_ready", in_ready0, 1);
        @(posedge clk); #1; in_valid0 = 1'b0;
        @(negedge clk);
        chk("illegal3_err", err_drop0, 1);
        in_src = 4'd11; in_valid0 = 1'b1;
        @(posedge clk); #1; in_valid0 = 1'b0;
        @(negedge clk);
        chk("illegal11_err", err_drop0, 1);
        @(negedge clk);
        chk("err_pulse_width", err_drop0, 0);
        expect_px(0, 5, 0, 10);
        push_pix(0, 2); drain();

        // Backpressure: src-5 FIFO fills, outputs held, then released in order.
        img_clear();
        out_ready = 1'b0;
        for (int p = 0; p < 5; p++) expect_px(0, p * 5, 0, 5 * (p + 1));
        for (int p = 1; p <= 4; p++) push(0, 5, p);
        @(negedge clk); in_src = 4'd5; in_psum = 14'd5; in_valid0 = 1'b1; #1;
        chk("src5_full_ready", in_ready0, 0);
        in_src = 4'd6; #1;
        chk("src6_ready", in_ready0, 1);
        in_valid0 = 1'b0;
        for (int s = 6; s <= 9; s++)
            for (int p = 1; p <= 4; p++) push(0, s, p);
        @(negedge clk);
        chk("held_valid", out_valid0, 1);
        chk("held_pix", out_pix0, 0);
        chk("held_vmem", out_vmem0, 5);
        held_pix = out_pix0; held_vm = out_vmem0;
        repeat (6) @(negedge clk);
        chk("stable_pix", out_pix0, 0);
        chk("stable_vmem", out_vmem0, 5);
        chk("stable_valid", out_valid0, 1);
        push_pix(0, 5);
        out_ready = 1'b1;
        drain();

        // Negative saturation over repeated timesteps on pixel 0.
        img_clear();
        for (int t = 0; t < 4; t++) begin
            expect_px(0, 0, 0, vexp[t]);
            push_pix(0, -8192); drain();
            ts_pulse();
        end

        // Reset mid-pixel with an output held: everything drops at once.
        img_clear();
        out_ready = 1'b0;
        push_pix(0, 1);
        push(0, 5, 7); push(0, 6, 7);
        @(negedge clk);
        rst_n = 1'b0; #1;
        chk("midrst_out_valid", out_valid0, 0);
        chk("midrst_out_pix", out_pix0, 0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        img_clear();
        expect_px(0, 0, 0, 5);
        push_pix(0, 1); drain();

        // SPE 2 full timestep of zero psums.
        img_clear();
        chk("u2_tsc_before", ts_complete2, 0);
        for (int r = 0; r < 21; r++)
            for (int c = 2; c < 21; c += 5) begin
                expect_px(2, r * 21 + c, 0, 0);
                push_pix(2, 0);
            end
        drain();
        chk("u2_tsc_after", ts_complete2, 1);
        expect_px(2, 2, 0, 0);
        push_pix(2, 0);
        repeat (10) @(negedge clk);
        chk("u2_stalled_after_complete", out_valid2, 0);
        ts_pulse();
        drain();
        chk("u2_tsc_cleared", ts_complete2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
